ccg_exhaustive_tester: RTL

- Driving end of a generated combinational circuit (CCG) interface: sources every input vector x[N_IN-1:0] in turn and compacts the returned outputs f[N_OUT-1:0] into a MISR signature.
- Sits beside each generated CCG netlist in the silicon/emulation harness.
- The signature is compared against the golden value from the AIG model, giving one pass/fail check per circuit.
- Sequential: run FSM, pattern counter, response-latency alignment pipe, MISR.

---
 rtl/ccg_exhaustive_tester_pkg.sv | 40 ++++
 rtl/ccg_exhaustive_tester_if.sv | 18 +
 rtl/ccg_exhaustive_tester_misr.sv | 52 +++++
 rtl/ccg_exhaustive_tester.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ccg_exhaustive_tester_pkg.sv
// ---------------------------------------------------------------------------
// ccg_test_pkg
// Shared definitions for the exhaustive CCG tester:
//   - ccg_state_e : run FSM state encoding
//   - POLY_DEF / SEED_DEF : default MISR polynomial and seed
//   - misr_next() : one MISR step, generic up to MISR_MAX_W bits
// ---------------------------------------------------------------------------
package ccg_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ccg_state_e;

    localparam logic [15:0] POLY_DEF   = 16'h1021;
    localparam logic [15:0] SEED_DEF   = 16'h0000;
    localparam int          MISR_MAX_W = 32;

    // One MISR step on the low 'width' bits: shift left, fold the bit that
    // falls out back in through the polynomial, then xor in the response.
    // Operands are carried at MISR_MAX_W bits so one function serves any
    // signature width up to 32.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] resp,
        input logic [MISR_MAX_W-1:0] poly,
        input logic [5:0]            width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] shifted;
        logic                  msb;
        mask    = (width >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        msb     = sig[width[4:0] - 5'd1];
        shifted = (sig << 32'd1) & mask;
        return (shifted ^ (msb ? poly : 32'd0) ^ resp) & mask;
    endfunction

endpackage

// File: rtl/ccg_exhaustive_tester_if.sv
// ---------------------------------------------------------------------------
// ccg_exhaustive_tester_if
// Pattern/response bus between the exhaustive tester and the generated
// combinational circuit under test.
//   pattern_o  : tester -> CCG, drives the CCG x inputs
//   response_i : CCG -> tester, the CCG f outputs
// Modports: master (tester side), slave (CCG side).
// ---------------------------------------------------------------------------
interface ccg_exhaustive_tester_if #(
    parameter int N_IN  = 7,
    parameter int N_OUT = 4
);
    logic [N_IN-1:0]  pattern_o;
    logic [N_OUT-1:0] response_i;

    modport master (output pattern_o, input response_i);
    modport slave  (input pattern_o, output response_i);
endinterface

// File: rtl/ccg_exhaustive_tester_misr.sv
// ---------------------------------------------------------------------------
// ccg_misr
// Multiple-input signature register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (loads load_val)
//   load      : load load_val (takes priority over en)
//   load_val  : seed value
//   en        : compress din into the signature this edge
//   din       : zero-extended response word
//   sig       : current signature (registered)
// ---------------------------------------------------------------------------
module ccg_misr
    import ccg_test_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIG_W-1:0] load_val,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    localparam logic [5:0] WIDTH = 6'(SIG_W);

    logic [SIG_W-1:0] sig_r;
    logic [SIG_W-1:0] sig_next_s;

    // Next signature value for an enabled compression
    always_comb begin
        sig_next_s = SIG_W'(misr_next(32'(sig_r), 32'(din), 32'(POLY), WIDTH));
    end

    // Signature register: reset/load to seed, otherwise compress or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= load_val;
        end else if (load) begin
            sig_r <= load_val;
        end else if (en) begin
            sig_r <= sig_next_s;
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule

// File: rtl/ccg_exhaustive_tester.sv
// ---------------------------------------------------------------------------
// ccg_exhaustive_tester
// Drives every input vector 0 .. 2^N_IN-1 into a generated combinational
// circuit and compacts the returned responses into a MISR signature.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (sampled in IDLE only)
//   abort      : end a run early (honoured in RUN/DRAIN)
//   bus        : master side of the pattern/response bus
//   busy       : high while in RUN or DRAIN
//   done       : one-cycle pulse when the signature is final
//   aborted    : sticky abort flag, cleared by the next start or rst
//   signature  : MISR state, stable outside RUN/DRAIN
// ---------------------------------------------------------------------------
module ccg_exhaustive_tester
    import ccg_test_pkg::*;
#(
    parameter int               N_IN     = 7,
    parameter int               N_OUT    = 4,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED     = SIG_W'(SEED_DEF),
    parameter int               RESP_LAT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    ccg_exhaustive_tester_if.master      bus,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic [SIG_W-1:0]             signature
);

    // Extra counter bit keeps the terminal-count compare from aliasing at wrap
    localparam logic [N_IN:0] LAST_CNT   = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] CNT_ONE    = (N_IN+1)'(1);
    localparam logic [2:0]    DRAIN_LAST = (RESP_LAT > 0) ? 3'(RESP_LAT - 1) : 3'd0;

    ccg_state_e     state_r;
    ccg_state_e     state_next_s;
    logic [N_IN:0]  cnt_r;
    logic [2:0]     drain_cnt_r;
    logic           busy_r;
    logic           done_r;
    logic           aborted_r;
    logic           start_run_s;
    logic           abort_take_s;
    logic           run_s;
    logic           valid_d_s;
    logic           misr_en_s;

    assign run_s = (state_r == RUN);

    // Next-state decode; abort beats the end-of-run transition
    always_comb begin
        state_next_s = state_r;
        start_run_s  = 1'b0;
        abort_take_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                    start_run_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next_s = IDLE;
                    abort_take_s = 1'b1;
                end else if (cnt_r == LAST_CNT) begin
                    if (RESP_LAT > 0) begin
                        state_next_s = DRAIN;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next_s = IDLE;
                    abort_take_s = 1'b1;
                end else if (drain_cnt_r == DRAIN_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            drain_cnt_r <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN) || (state_next_s == DRAIN);
            done_r  <= (state_next_s == DONE);
            // Count only while staying in RUN; entering or leaving RUN clears it
            if (run_s && (state_next_s == RUN)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= '0;
            end
            if ((state_r == DRAIN) && (state_next_s == DRAIN)) begin
                drain_cnt_r <= drain_cnt_r + 3'd1;
            end else begin
                drain_cnt_r <= 3'd0;
            end
            if (start_run_s) begin
                aborted_r <= 1'b0;
            end else if (abort_take_s) begin
                aborted_r <= 1'b1;
            end else begin
                aborted_r <= aborted_r;
            end
        end
    end

    // Valid bit follows each presented pattern by RESP_LAT cycles
    generate
        if (RESP_LAT > 0) begin : g_pipe
            logic [RESP_LAT-1:0] vpipe_r;

            // Latency pipe; flushed by reset and by an honoured abort
            always_ff @(posedge clk) begin
                if (rst) begin
                    vpipe_r <= '0;
                end else if (abort_take_s) begin
                    vpipe_r <= '0;
                end else begin
                    vpipe_r <= RESP_LAT'({vpipe_r, run_s});
                end
            end

            assign valid_d_s = vpipe_r[RESP_LAT-1];
        end else begin : g_nopipe
            assign valid_d_s = run_s;
        end
    endgenerate

    // The compression on the abort edge is dropped so the signature keeps
    // its last completed value
    assign misr_en_s = valid_d_s && !abort_take_s;

    ccg_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_run_s),
        .load_val (SEED),
        .en       (misr_en_s),
        .din      (SIG_W'(bus.response_i)),
        .sig      (signature)
    );

    assign bus.pattern_o = cnt_r[N_IN-1:0];
    assign busy          = busy_r;
    assign done          = done_r;
    assign aborted       = aborted_r;

endmodule
